// File: rtl/sa_wresp_router_pkg.sv
// ============================================================================
// sa_wresp_router_pkg : BRESP encodings, merge priority and FSM states
// Revision: 1.0
// ============================================================================
`default_nettype none

package sa_wresp_router_pkg;

    localparam int RESP_W = 2;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'd0;
    localparam logic [RESP_W-1:0] RESP_EXOKAY = 2'd1;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'd2;
    localparam logic [RESP_W-1:0] RESP_DECERR = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_MERGE = 1'b1
    } state_e;

    // Worst of two split-half responses: DECERR > SLVERR > EXOKAY > OKAY.
    function automatic logic [RESP_W-1:0] resp_merge(
        input logic [RESP_W-1:0] a,
        input logic [RESP_W-1:0] b
    );
        if ((a == RESP_DECERR) || (b == RESP_DECERR)) begin
            return RESP_DECERR;
        end else if ((a == RESP_SLVERR) || (b == RESP_SLVERR)) begin
            return RESP_SLVERR;
        end else if ((a == RESP_EXOKAY) || (b == RESP_EXOKAY)) begin
            return RESP_EXOKAY;
        end else begin
            return RESP_OKAY;
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// sync_fifo : full-flop synchronous FIFO with first-word fall-through head
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_rd;
    logic             do_wr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign rd_data_o = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a push into a full FIFO is kept then.
    assign do_rd = rd_en_i & ~empty_o;
    assign do_wr = wr_en_i & (~full_o | do_rd);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_rd) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (do_wr && !do_rd) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!do_wr && do_rd) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sa_wresp_router.sv
// ============================================================================
// sa_wresp_router : slave-side B return path; merges 4KB-split pairs and
// routes each response to its master. Option: SA_WRESP_ID_CHECK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sa_wresp_router
    import sa_wresp_router_pkg::*;
#(
    parameter int MST_AMT         = 3,
    parameter int OUTSTANDING_AMT = 8,
    parameter int MST_ID_W        = $clog2(MST_AMT),
    parameter int TRANS_MST_ID_W  = 5,
    parameter int TRANS_SLV_ID_W  = TRANS_MST_ID_W + MST_ID_W,
    parameter int TRANS_WR_RESP_W = 2
) (
    input  logic                                ACLK_i,
    input  logic                                ARESET_i,
    input  logic                                ord_wr_en_i,
    input  logic                                ord_crossing_flag_i,
    output logic                                ord_full_o,
    input  logic [TRANS_SLV_ID_W-1:0]           s_BID_i,
    input  logic [TRANS_WR_RESP_W-1:0]          s_BRESP_i,
    input  logic                                s_BVALID_i,
    output logic                                s_BREADY_o,
    output logic [TRANS_MST_ID_W*MST_AMT-1:0]   m_BID_o,
    output logic [TRANS_WR_RESP_W*MST_AMT-1:0]  m_BRESP_o,
    output logic [MST_AMT-1:0]                  m_BVALID_o,
    input  logic [MST_AMT-1:0]                  m_BREADY_i,
    output logic                                id_err_o
);

    state_e                       state_q, state_d;
    logic                         ord_flag;
    logic                         ord_empty;
    logic                         s_hs;
    logic                         absorb;
    logic                         sel_ready;
    logic                         slot_oob;
    logic                         drain;

    logic                         slot_valid_q, slot_valid_d;
    logic [MST_ID_W-1:0]          slot_idx_q,   slot_idx_d;
    logic [TRANS_MST_ID_W-1:0]    slot_id_q,    slot_id_d;
    logic [TRANS_WR_RESP_W-1:0]   slot_resp_q,  slot_resp_d;
    logic [TRANS_SLV_ID_W-1:0]    merge_id_q,   merge_id_d;
    logic [TRANS_WR_RESP_W-1:0]   merge_resp_q, merge_resp_d;

    sync_fifo #(
        .WIDTH (1),
        .DEPTH (OUTSTANDING_AMT)
    ) u_ord_fifo (
        .clk_i     (ACLK_i),
        .rst_i     (ARESET_i),
        .wr_en_i   (ord_wr_en_i),
        .wr_data_i (ord_crossing_flag_i),
        .rd_en_i   (s_hs),
        .rd_data_o (ord_flag),
        .full_o    (ord_full_o),
        .empty_o   (ord_empty)
    );

    always_comb begin
        sel_ready = 1'b0;
        for (int k = 0; k < MST_AMT; k++) begin
            if (slot_idx_q == MST_ID_W'(k)) begin
                sel_ready = m_BREADY_i[k];
            end
        end
    end

    // Responses for a nonexistent master have no taker and are discarded after one cycle.
    assign slot_oob = (32'(slot_idx_q) >= MST_AMT);
    assign drain    = slot_valid_q & (slot_oob | sel_ready);
    assign absorb   = (state_q == ST_IDLE) & ord_flag;

    assign s_BREADY_o = ~ord_empty & (absorb | ~slot_valid_q | drain);
    assign s_hs       = s_BVALID_i & s_BREADY_o;

    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            state_q      <= ST_IDLE;
            slot_valid_q <= 1'b0;
            slot_idx_q   <= '0;
            slot_id_q    <= '0;
            slot_resp_q  <= '0;
            merge_id_q   <= '0;
            merge_resp_q <= '0;
        end else begin
            state_q      <= state_d;
            slot_valid_q <= slot_valid_d;
            slot_idx_q   <= slot_idx_d;
            slot_id_q    <= slot_id_d;
            slot_resp_q  <= slot_resp_d;
            merge_id_q   <= merge_id_d;
            merge_resp_q <= merge_resp_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        slot_valid_d = slot_valid_q & ~drain;
        slot_idx_d   = slot_idx_q;
        slot_id_d    = slot_id_q;
        slot_resp_d  = slot_resp_q;
        merge_id_d   = merge_id_q;
        merge_resp_d = merge_resp_q;

        if (s_hs) begin
            case (state_q)
                ST_IDLE: begin
                    if (absorb) begin
                        merge_id_d   = s_BID_i;
                        merge_resp_d = s_BRESP_i;
                        state_d      = ST_MERGE;
                    end else begin
                        slot_valid_d = 1'b1;
                        slot_idx_d   = s_BID_i[TRANS_SLV_ID_W-1 -: MST_ID_W];
                        slot_id_d    = s_BID_i[TRANS_MST_ID_W-1:0];
                        slot_resp_d  = s_BRESP_i;
                    end
                end
                ST_MERGE: begin
                    // The held first-half ID identifies the transaction.
                    slot_valid_d = 1'b1;
                    slot_idx_d   = merge_id_q[TRANS_SLV_ID_W-1 -: MST_ID_W];
                    slot_id_d    = merge_id_q[TRANS_MST_ID_W-1:0];
                    slot_resp_d  = resp_merge(merge_resp_q, s_BRESP_i);
                    state_d      = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < MST_AMT; k++) begin : g_lane
        assign m_BVALID_o[k] = slot_valid_q & (slot_idx_q == MST_ID_W'(k));
        assign m_BID_o[k*TRANS_MST_ID_W +: TRANS_MST_ID_W]    = slot_id_q;
        assign m_BRESP_o[k*TRANS_WR_RESP_W +: TRANS_WR_RESP_W] = slot_resp_q;
    end

`ifdef SA_WRESP_ID_CHECK_EN
    logic id_err_q;

    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            id_err_q <= 1'b0;
        end else begin
            id_err_q <= s_hs & (state_q == ST_MERGE) & (s_BID_i != merge_id_q);
        end
    end

    assign id_err_o = id_err_q;
`else
    assign id_err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sa_wresp_router.sv
// ============================================================================
// tb_sa_wresp_router : directed + randomized scoreboard bench for sa_wresp_router
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sa_wresp_router;

    localparam int MST  = 3;
    localparam int IDW  = 5;
    localparam int SIDW = 7;
    localparam int RW   = 2;
    localparam int DEP  = 8;

    logic             clk = 1'b0;
    logic             ARESET_i;
    logic             ord_wr_en_i;
    logic             ord_crossing_flag_i;
    logic             ord_full_o;
    logic [SIDW-1:0]  s_BID_i;
    logic [RW-1:0]    s_BRESP_i;
    logic             s_BVALID_i;
    logic             s_BREADY_o;
    logic [IDW*MST-1:0] m_BID_o;
    logic [RW*MST-1:0]  m_BRESP_o;
    logic [MST-1:0]   m_BVALID_o;
    logic [MST-1:0]   m_BREADY_i;
    logic             id_err_o;

    always #5 clk = ~clk;

    sa_wresp_router dut (
        .ACLK_i              (clk),
        .ARESET_i            (ARESET_i),
        .ord_wr_en_i         (ord_wr_en_i),
        .ord_crossing_flag_i (ord_crossing_flag_i),
        .ord_full_o          (ord_full_o),
        .s_BID_i             (s_BID_i),
        .s_BRESP_i           (s_BRESP_i),
        .s_BVALID_i          (s_BVALID_i),
        .s_BREADY_o          (s_BREADY_o),
        .m_BID_o             (m_BID_o),
        .m_BRESP_o           (m_BRESP_o),
        .m_BVALID_o          (m_BVALID_o),
        .m_BREADY_i          (m_BREADY_i),
        .id_err_o            (id_err_o)
    );

    typedef struct {
        int          idx;
        logic [4:0]  id;
        logic [1:0]  resp;
    } exp_t;

    int          vectors = 0;
    int          errors  = 0;
    bit          ordq[$];
    exp_t        expq[$];
    bit          held_valid = 0;
    logic [6:0]  held_bid;
    logic [1:0]  held_resp;
    bit          exp_err = 0;
    bit          slv_q[$];
    bit          push_done = 0;
    bit          rnd_ready = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input bit f);
        ord_wr_en_i         = 1'b1;
        ord_crossing_flag_i = f;
        tick();
        ord_wr_en_i         = 1'b0;
    endtask

    task automatic send_b(input logic [6:0] bid, input logic [1:0] resp);
        bit ok = 0;
        s_BVALID_i = 1'b1;
        s_BID_i    = bid;
        s_BRESP_i  = resp;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (s_BREADY_o) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("send_b_timeout", 0, 1);
        tick();
        s_BVALID_i = 1'b0;
    endtask

    function automatic logic [6:0] mkbid(input int i);
        logic [1:0] ix = 2'(i % 3);
        logic [4:0] id = 5'(i);
        return {ix, id};
    endfunction

    // Reference model and scoreboard: follows the B-order stream at the spec level.
    always @(negedge clk) begin
        int         nvalid;
        bit         hs;
        bit         f;
        bit         new_err;
        logic [6:0] bid;
        logic [1:0] resp;
        exp_t       e;
        if (ARESET_i) begin
            ordq.delete();
            expq.delete();
            held_valid = 0;
            exp_err    = 0;
        end else begin
            chk("id_err", id_err_o, exp_err);
            nvalid = 0;
            for (int k = 0; k < MST; k++) begin
                if (m_BVALID_o[k]) nvalid++;
                if (m_BVALID_o[k] && m_BREADY_i[k]) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_resp", 1, 0);
                    end else begin
                        e = expq.pop_front();
                        chk("out_lane", k, e.idx);
                        chk("out_id", m_BID_o[k*IDW +: IDW], e.id);
                        chk("out_resp", m_BRESP_o[k*RW +: RW], e.resp);
                    end
                end
            end
            if (nvalid > 1) chk("onehot_valid", nvalid, 1);
            chk("ord_full", ord_full_o, ordq.size() == DEP);
            if (ordq.size() == 0) chk("bready_empty", s_BREADY_o, 0);

            new_err = 0;
            hs = s_BVALID_i && s_BREADY_o;
            if (hs) begin
                if (ordq.size() == 0) begin
                    chk("pop_empty", 1, 0);
                end else begin
                    f = ordq.pop_front();
                    if (f) begin
                        held_valid = 1;
                        held_bid   = s_BID_i;
                        held_resp  = s_BRESP_i;
                    end else begin
                        if (held_valid) begin
                            bid     = held_bid;
                            resp    = (held_resp > s_BRESP_i) ? held_resp : s_BRESP_i;
                            new_err = (s_BID_i != held_bid);
                            held_valid = 0;
                        end else begin
                            bid  = s_BID_i;
                            resp = s_BRESP_i;
                        end
                        e.idx  = int'(bid[6:5]);
                        e.id   = bid[4:0];
                        e.resp = resp;
                        if (e.idx < MST) expq.push_back(e);
                    end
                end
            end
            if (ord_wr_en_i && ordq.size() < DEP) ordq.push_back(ord_crossing_flag_i);
`ifdef SA_WRESP_ID_CHECK_EN
            exp_err = new_err;
`else
            exp_err = 0;
`endif
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int  sent;
        ARESET_i            = 1'b1;
        ord_wr_en_i         = 1'b0;
        ord_crossing_flag_i = 1'b0;
        s_BID_i             = '0;
        s_BRESP_i           = '0;
        s_BVALID_i          = 1'b0;
        m_BREADY_i          = 3'b111;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_bvalid", m_BVALID_o, 0);
        chk("rst_bid", m_BID_o, 0);
        chk("rst_bresp", m_BRESP_o, 0);
        chk("rst_bready", s_BREADY_o, 0);
        chk("rst_full", ord_full_o, 0);
        chk("rst_iderr", id_err_o, 0);
        tick();
        ARESET_i = 1'b0;

        // Simple routed response, 1-cycle latency.
        push1(0);
        send_b(7'b01_00011, 2'd0);
        @(negedge clk);
        chk("t1_valid", m_BVALID_o, 3'b010);
        chk("t1_id", m_BID_o[IDW +: IDW], 3);
        chk("t1_resp", m_BRESP_o[RW +: RW], 0);
        chk("t1_empty_bready", s_BREADY_o, 0);
        tick();

        // Split pair merged into one SLVERR response.
        push1(1);
        push1(0);
        send_b(7'b00_01010, 2'd2);
        @(negedge clk);
        chk("t2_absorb_novalid", m_BVALID_o, 0);
        tick();
        send_b(7'b00_01010, 2'd0);
        @(negedge clk);
        chk("t2_valid", m_BVALID_o, 3'b001);
        chk("t2_resp", m_BRESP_o[0 +: RW], 2);
        chk("t2_id", m_BID_o[0 +: IDW], 10);
        tick();

        // B offered with empty order FIFO is held off.
        s_BVALID_i = 1'b1;
        s_BID_i    = 7'b10_00101;
        s_BRESP_i  = 2'd1;
        repeat (5) begin
            @(negedge clk);
            chk("t3_hold", s_BREADY_o, 0);
        end
        tick();
        push1(0);
        @(negedge clk);
        chk("t3_accept", s_BREADY_o, 1);
        tick();
        s_BVALID_i = 1'b0;
        repeat (2) tick();

        // Fill the FIFO, stall the masters, then stream back-to-back.
        m_BREADY_i = 3'b000;
        repeat (DEP) push1(0);
        @(negedge clk);
        chk("t4_full", ord_full_o, 1);
        tick();
        send_b(mkbid(0), 2'd0);
        s_BVALID_i = 1'b1;
        s_BID_i    = mkbid(1);
        s_BRESP_i  = 2'd1;
        repeat (3) begin
            @(negedge clk);
            chk("t4_stall", s_BREADY_o, 0);
        end
        tick();
        m_BREADY_i = 3'b111;
        sent = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t4_b2b", m_BVALID_o != 0, 1);
            if (s_BVALID_i && s_BREADY_o) sent++;
            tick();
            if (sent >= 8) begin
                s_BVALID_i = 1'b0;
            end else begin
                s_BID_i   = mkbid(sent);
                s_BRESP_i = 2'(sent % 4);
            end
        end
        repeat (2) tick();

        // Reset while a first half is held.
        push1(1);
        push1(0);
        send_b(7'b01_01111, 2'd3);
        ARESET_i = 1'b1;
        tick();
        @(negedge clk);
        chk("t5_bvalid", m_BVALID_o, 0);
        chk("t5_bid", m_BID_o, 0);
        chk("t5_bresp", m_BRESP_o, 0);
        chk("t5_bready", s_BREADY_o, 0);
        chk("t5_full", ord_full_o, 0);
        chk("t5_iderr", id_err_o, 0);
        tick();
        ARESET_i = 1'b0;
        push1(0);
        send_b(7'b10_00100, 2'd1);
        @(negedge clk);
        chk("t5_valid", m_BVALID_o, 3'b100);
        chk("t5_id", m_BID_o[2*IDW +: IDW], 4);
        chk("t5_resp", m_BRESP_o[2*RW +: RW], 1);
        tick();

`ifdef SA_WRESP_ID_CHECK_EN
        push1(1);
        push1(0);
        send_b(7'd7, 2'd0);
        send_b(7'd9, 2'd2);
        @(negedge clk);
        chk("t6_iderr", id_err_o, 1);
        chk("t6_id", m_BID_o[0 +: IDW], 7);
        chk("t6_resp", m_BRESP_o[0 +: RW], 2);
        @(negedge clk);
        chk("t6_iderr_pulse", id_err_o, 0);
        tick();
`endif

        // Randomized traffic.
        rnd_ready = 1;
        fork
            begin
                while (rnd_ready) begin
                    tick();
                    if (rnd_ready) m_BREADY_i = 3'($urandom);
                end
            end
        join_none
        fork
            begin
                int pushed = 0;
                bit pend   = 0;
                bit f;
                while (pushed < 150 || pend) begin
                    tick();
                    ord_wr_en_i = 1'b0;
                    if ($urandom_range(0, 2) != 0 && !ord_full_o) begin
                        f = pend ? 1'b0 : ($urandom_range(0, 2) == 0);
                        ord_wr_en_i         = 1'b1;
                        ord_crossing_flag_i = f;
                        slv_q.push_back(f);
                        pend = f;
                        pushed++;
                    end
                end
                tick();
                ord_wr_en_i = 1'b0;
                push_done = 1;
            end
            begin
                bit         f;
                int         waitc;
                logic [6:0] bid;
                while (!push_done || slv_q.size() != 0) begin
                    waitc = 0;
                    while (slv_q.size() == 0 && !push_done && waitc < 2000) begin
                        tick();
                        waitc++;
                    end
                    if (waitc >= 2000) chk("slave_wait_timeout", 0, 1);
                    if (slv_q.size() == 0) continue;
                    f   = slv_q.pop_front();
                    bid = 7'($urandom);
                    send_b(bid, 2'($urandom));
                    if (f) begin
                        waitc = 0;
                        while (slv_q.size() == 0 && waitc < 2000) begin
                            tick();
                            waitc++;
                        end
                        if (slv_q.size() == 0) begin
                            chk("second_half_timeout", 0, 1);
                        end else begin
                            f = slv_q.pop_front();
                            send_b(bid, 2'($urandom));
                        end
                    end
                    repeat ($urandom_range(0, 2)) tick();
                end
            end
        join
        rnd_ready = 0;
        tick();
        m_BREADY_i = 3'b111;
        for (int i = 0; i < 200 && (expq.size() != 0 || held_valid); i++) @(negedge clk);
        chk("drain_expq", expq.size(), 0);
        chk("drain_ordq", ordq.size(), 0);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sa_wresp_router.md
Name: sa_wresp_router

Overview:
- Slave-side write-response (B) return path of the interconnect.
- Counterpart to the slave-arbiter write-address channel: accepts one B response per issued AW from the slave and strips the master-index MSBs from BID.
- Merges the two B responses of a 4KB-split burst into one response and routes the result to the originating master's dispatcher.
- One instance per slave port.

Parameters:
- MST_AMT, 3, number of masters.
- OUTSTANDING_AMT, 8, depth of the AW order FIFO (max outstanding AWs toward this slave).
- MST_ID_W, $clog2(MST_AMT), master-index width.
- TRANS_MST_ID_W, 5, master-side transaction ID width.
- TRANS_SLV_ID_W, TRANS_MST_ID_W+MST_ID_W, slave-side ID width; master index occupies the MSBs.
- TRANS_WR_RESP_W, 2, BRESP width.

Ports:
- ACLK_i  in  1  clock.
- ARESET_i  in  1  synchronous reset, active-high.
- ord_wr_en_i  in  1  push one AW-order entry; asserted once per AW half issued to the slave.
- ord_crossing_flag_i  in  1  1 = this AW is the first half of a 4KB split.
- ord_full_o  out  1  order FIFO full; the address channel must stall.
- s_BID_i  in  TRANS_SLV_ID_W  slave BID.
- s_BRESP_i  in  TRANS_WR_RESP_W  slave BRESP.
- s_BVALID_i  in  1  slave BVALID.
- s_BREADY_o  out  1  slave BREADY.
- m_BID_o  out  TRANS_MST_ID_W*MST_AMT  per-master BID, flattened with master 0 in the LSBs.
- m_BRESP_o  out  TRANS_WR_RESP_W*MST_AMT  per-master BRESP, flattened.
- m_BVALID_o  out  MST_AMT  per-master BVALID.
- m_BREADY_i  in  MST_AMT  per-master BREADY.
- id_err_o  out  1  split-pair ID mismatch pulse (see Optional Feature).

Behaviour:
- Slave ordering: slaves return B in AW issue order. The order FIFO head corresponds to the next B.
- Order FIFO:
  - Full-flop FIFO, 1 bit wide, OUTSTANDING_AMT deep.
  - Push on ord_wr_en_i. A push while ord_full_o=1 is illegal; the write is dropped.
  - Pop on every s_BVALID_i & s_BREADY_o handshake.
- State machine, 2 states:
  - IDLE: no split half held.
  - MERGE: first-half response held in a merge register (ID, RESP).
- Acceptance gate: s_BREADY_o = order FIFO not empty & (next-state absorb | output slot free-or-draining).
  - FIFO empty → s_BREADY_o=0, even when s_BVALID_i=1.
- Handshake in IDLE, FIFO head flag=1 (absorb):
  - Store BID and BRESP in the merge register; go to MERGE.
  - Nothing is forwarded; the output slot is not required.
- Handshake in IDLE, FIFO head flag=0:
  - Load the output slot: master index = BID[TRANS_SLV_ID_W-1-:MST_ID_W], ID = low TRANS_MST_ID_W bits, RESP = BRESP.
- Handshake in MERGE (head flag is 0 by construction):
  - Load the output slot with the merged RESP = numeric max(held, new), i.e. DECERR > SLVERR > EXOKAY > OKAY.
  - Return to IDLE.
- Output slot:
  - Single register stage: valid, master index, ID, RESP.
  - m_BVALID_o[k] = slot_valid & (idx==k). m_BID_o and m_BRESP_o drive the slot value on every lane; only the selected lane is valid.
  - Slot clears on m_BREADY_i[idx]. Drain and reload in the same cycle are allowed, giving 1 response per cycle.
- Latency: 1 cycle from slave handshake to m_BVALID_o (non-split). A split pair needs 2 slave handshakes, then 1 cycle.
- Simultaneous events: push and pop in the same cycle with the FIFO full are allowed (count unchanged). Push and pop with the FIFO empty: the pop is not performed because s_BREADY_o=0.
- Master index ≥ MST_AMT: the slot still loads, no m_BVALID_o lane asserts, and the response is dropped next cycle.
- Reset (any cycle, including mid-merge): FIFO empty, state IDLE, slot invalid.
  - Reset values: s_BREADY_o=0, m_BVALID_o=0, m_BID_o=0, m_BRESP_o=0, ord_full_o=0, id_err_o=0.

Optional Feature:
- Macro: SA_WRESP_ID_CHECK_EN.
- Defined: in MERGE, a second-half BID differing from the held BID pulses id_err_o for 1 cycle. The merge still completes using the held ID.
- Undefined: id_err_o is tied to 0 and no comparator is built.

Decomposition:
- Shared package:
  - BRESP encodings: OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3.
  - Merge-priority function.
  - IDLE/MERGE state enum.
- Sub-module: existing sync_fifo, instantiated as the order FIFO (full-flop type, width 1). No other sub-module.

Test Plan:
- Push flag=0, then B ID=0b01_00011, RESP=OKAY → next cycle m_BVALID_o=3'b010, m_BID_o lane1=5'd3, RESP=0; FIFO empty.
- Push flags 1,0, then B RESP=SLVERR and B RESP=OKAY, same ID → exactly one response to master 0 with RESP=2; no m_BVALID_o after the first handshake.
- B valid with FIFO empty → s_BREADY_o=0 held for 5 cycles; after a push, accepted on the next cycle.
- Push 8 entries → ord_full_o=1. Hold m_BREADY_i=0 → s_BREADY_o drops after one accepted B. Release → 8 responses back-to-back, 1 per cycle.
- Assert ARESET_i in MERGE → all outputs 0; the next flag=0 B routes normally with no merge.
- SA_WRESP_ID_CHECK_EN defined, split pair with BIDs 7 and 9 → id_err_o=1 for 1 cycle, merged response uses ID 7.
